// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART Wishbone CSR slice: register byte addresses,
// STS/IER bit positions and the TX drain FSM state type.
package wb_uart_pkg;

  localparam logic [4:0] ADR_RXD = 5'h00;
  localparam logic [4:0] ADR_TXD = 5'h04;
  localparam logic [4:0] ADR_STS = 5'h08;
  localparam logic [4:0] ADR_DIV = 5'h0C;
  localparam logic [4:0] ADR_IER = 5'h10;

  localparam int STS_UTX_BUSY  = 0;
  localparam int STS_RFIFO_EF  = 1;
  localparam int STS_TXF_EMPTY = 2;
  localparam int STS_TXF_FULL  = 3;
  localparam int STS_TXO       = 4;
  localparam int STS_RXU       = 5;
  localparam int STS_LVL_LSB   = 8;

  localparam int IER_RX_AVAIL  = 0;
  localparam int IER_TXF_EMPTY = 1;
  localparam int IER_ERR       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT_B = 2'd2,
    WAIT_D = 2'd3
  } tx_state_e;

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone B3 classic bus bundle between the CPU interconnect and the UART CSR slave.
interface wb_uart_if;
  // A request is cyc & stb; the slave answers with a single registered ack
  // cycle (one wait state), read data valid only while ack is high.
  logic [4:0]  adr;
  logic [31:0] dat_w;
  logic        we;
  logic        stb;
  logic [3:0]  sel;
  logic        cyc;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output adr, dat_w, we, stb, sel, cyc, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, sel, cyc, output dat_r, ack);
endinterface

// File: rtl/wb_uart_txfifo.sv
// Single-clock byte FIFO with level/full/empty; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module wb_uart_txfifo #(
  parameter int P_DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_push,
  input  logic [7:0]               iv_data,
  input  logic                     i_pop,
  output logic [7:0]               ov_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(P_DEPTH):0] ov_level
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [P_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign o_empty = (ov_level == '0);
  assign o_full  = (ov_level == LW'(P_DEPTH));
  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);
  assign ov_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= iv_data;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ov_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   ov_level <= ov_level + 1'b1;
        2'b01:   ov_level <= ov_level - 1'b1;
        default: ov_level <= ov_level;
      endcase
    end
  end
endmodule

// File: rtl/wb_uart_regs.sv
// UART CSR slave: RX pop, TX FIFO with autonomous drain FSM, baud divisor, sticky errors.
// Define WB_UART_IRQ_EN to build the IER register and the level interrupt.
module wb_uart_regs
  import wb_uart_pkg::*;
#(
  parameter int P_TXF_DEPTH = 16,
  parameter int P_DIV_W     = 16,
  parameter int P_DIV_RST   = 868
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  wb_uart_if.slave           wbs,
  output logic               o_ctrl_utx_start,
  output logic [7:0]         ov_ctrl_utx_data,
  output logic               o_ctrl_rfifo_rd,
  output logic [P_DIV_W-1:0] ov_ctrl_baud_div,
  output logic               o_irq,
  input  logic               i_sts_utx_busy,
  input  logic               i_sts_rfifo_ef,
  input  logic [7:0]         iv_sts_rfifo_data,
  output tx_state_e          o_dbg_state
);
  localparam int LW = $clog2(P_TXF_DEPTH) + 1;

  logic [4:0]         adr_w;
  logic               acc, wr, rd;
  logic               txf_push, txf_pop, txf_full, txf_empty;
  logic [7:0]         txf_head;
  logic [LW-1:0]      txf_level;
  logic [8:0]         lvl9;
  logic               txo_q, rxu_q;
  logic [P_DIV_W-1:0] div_q;
  logic [2:0]         ier_rd;
  logic [31:0]        rdata;
  tx_state_e          state_q;
  logic [1:0]         wait_cnt_q;
  logic               unused_bits;

  assign adr_w    = {wbs.adr[4:2], 2'b00};
  assign acc      = wbs.cyc & wbs.stb & ~wbs.ack;
  assign wr       = acc & wbs.we;
  assign rd       = acc & ~wbs.we;
  assign txf_push = wr & (adr_w == ADR_TXD);
  assign txf_pop  = (state_q == LAUNCH);
  assign lvl9     = 9'(txf_level);
  assign unused_bits = ^{wbs.sel, wbs.adr[1:0], wbs.dat_w, lvl9[8]};

  assign ov_ctrl_baud_div = div_q;
  assign o_dbg_state      = state_q;

  wb_uart_txfifo #(.P_DEPTH(P_TXF_DEPTH)) u_txfifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_push   (txf_push),
    .iv_data  (wbs.dat_w[7:0]),
    .i_pop    (txf_pop),
    .ov_data  (txf_head),
    .o_full   (txf_full),
    .o_empty  (txf_empty),
    .ov_level (txf_level)
  );

  always_comb begin
    rdata = '0;
    case (adr_w)
      ADR_RXD: if (!i_sts_rfifo_ef) rdata[7:0] = iv_sts_rfifo_data;
      ADR_STS: begin
        rdata[STS_UTX_BUSY]  = i_sts_utx_busy;
        rdata[STS_RFIFO_EF]  = i_sts_rfifo_ef;
        rdata[STS_TXF_EMPTY] = txf_empty;
        rdata[STS_TXF_FULL]  = txf_full;
        rdata[STS_TXO]       = txo_q;
        rdata[STS_RXU]       = rxu_q;
        rdata[STS_LVL_LSB +: 8] = lvl9[7:0];
      end
      ADR_DIV: rdata[P_DIV_W-1:0] = div_q;
      ADR_IER: rdata[2:0] = ier_rd;
      default: rdata = '0;
    endcase
  end

  // All register side effects land on the same edge that raises ack.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wbs.ack         <= 1'b0;
      wbs.dat_r       <= '0;
      o_ctrl_rfifo_rd <= 1'b0;
      txo_q           <= 1'b0;
      rxu_q           <= 1'b0;
      div_q           <= P_DIV_W'(P_DIV_RST);
    end else begin
      wbs.ack         <= acc;
      wbs.dat_r       <= rd ? rdata : '0;
      o_ctrl_rfifo_rd <= rd & (adr_w == ADR_RXD) & ~i_sts_rfifo_ef;
      if (rd && adr_w == ADR_RXD && i_sts_rfifo_ef)
        rxu_q <= 1'b1;
      else if (wr && adr_w == ADR_STS && wbs.dat_w[STS_RXU])
        rxu_q <= 1'b0;
      if (txf_push && txf_full && !txf_pop)
        txo_q <= 1'b1;
      else if (wr && adr_w == ADR_STS && wbs.dat_w[STS_TXO])
        txo_q <= 1'b0;
      // A zero divisor would stall the baud generator, so it is promoted to 1.
      if (wr && adr_w == ADR_DIV)
        div_q <= (wbs.dat_w[P_DIV_W-1:0] == '0) ? P_DIV_W'(1) : wbs.dat_w[P_DIV_W-1:0];
    end
  end

`ifdef WB_UART_IRQ_EN
  logic [2:0] ier_q;
  logic       irq_q;
  assign ier_rd = ier_q;
  assign o_irq  = irq_q;
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr && adr_w == ADR_IER) ier_q <= wbs.dat_w[2:0];
      irq_q <= |(ier_q & {txo_q | rxu_q, txf_empty, ~i_sts_rfifo_ef});
    end
  end
`else
  assign ier_rd = '0;
  assign o_irq  = 1'b0;
`endif

  // WAIT_B gives the core 4 cycles to raise busy before the byte is written off.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q          <= IDLE;
      wait_cnt_q       <= '0;
      o_ctrl_utx_start <= 1'b0;
      ov_ctrl_utx_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!txf_empty && !i_sts_utx_busy) begin
            state_q          <= LAUNCH;
            o_ctrl_utx_start <= 1'b1;
            ov_ctrl_utx_data <= txf_head;
          end
        end
        LAUNCH: begin
          o_ctrl_utx_start <= 1'b0;
          wait_cnt_q       <= '0;
          state_q          <= WAIT_B;
        end
        WAIT_B: begin
          if (i_sts_utx_busy)        state_q    <= WAIT_D;
          else if (wait_cnt_q == 2'd3) state_q  <= IDLE;
          else                       wait_cnt_q <= wait_cnt_q + 2'd1;
        end
        WAIT_D: if (!i_sts_utx_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_uart_regs.sv
// Bench for wb_uart_regs: directed register scenarios plus randomized bus traffic
// against a queue-based register/FIFO model.
module tb_wb_uart_regs;
  import wb_uart_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, rfifo_rd, irq;
  logic [7:0]  utx_data;
  logic [15:0] baud;
  logic        busy = 1'b0;
  logic        ef = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  tx_state_e   dbg;

  always #5 clk = ~clk;

  wb_uart_if wb();

  wb_uart_regs dut (
    .i_clk             (clk),
    .i_arst_n          (rst_n),
    .wbs               (wb),
    .o_ctrl_utx_start  (start),
    .ov_ctrl_utx_data  (utx_data),
    .o_ctrl_rfifo_rd   (rfifo_rd),
    .ov_ctrl_baud_div  (baud),
    .o_irq             (irq),
    .i_sts_utx_busy    (busy),
    .i_sts_rfifo_ef    (ef),
    .iv_sts_rfifo_data (rx_data),
    .o_dbg_state       (dbg)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] m_div = 16'd868;
  logic        m_txo = 1'b0;
  logic        m_rxu = 1'b0;
  logic [2:0]  m_ier = 3'd0;
  int          rd_exp = 0;
  int          rd_seen = 0;
  int          starts_seen = 0;
  int          busy_mode = 0;
  int          busy_cnt = 0;
  bit          pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // busy_mode: 0 low, 1 held high, 2 core model (busy 1 cycle after start, 20 cycles)
  initial forever begin
    @(posedge clk); #1;
    if (busy_mode == 2) begin
      if (pend) begin busy_cnt = 20; pend = 1'b0; end
      else if (busy_cnt > 0) busy_cnt--;
      busy = (busy_cnt > 0);
      if (start) pend = 1'b1;
    end else begin
      busy = (busy_mode == 1);
      busy_cnt = 0;
      pend = 1'b0;
    end
  end

  logic prev_start = 1'b0, prev_ack = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_ack = 1'b0;
      prev_busy = busy;
    end else begin
      chk("baud_div", 32'(baud), 32'(m_div));
`ifndef WB_UART_IRQ_EN
      chk("irq_tied", 32'(irq), 32'd0);
`endif
      if (start) begin
        starts_seen++;
        chk("start_width", 32'(prev_start), 32'd0);
        chk("start_while_busy", 32'(prev_busy), 32'd0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL start_unexpected: got start data %h want no start", utx_data);
        end else chk("start_data", 32'(utx_data), 32'(exp_q.pop_front()));
      end
      if (wb.ack) chk("ack_width", 32'(prev_ack), 32'd0);
      if (rfifo_rd) begin
        rd_seen++;
        chk("rd_in_ack", 32'(wb.ack), 32'd1);
      end
      prev_start = start;
      prev_ack = wb.ack;
      prev_busy = busy;
    end
  end

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    case ({a[4:2], 2'b00})
      ADR_TXD: if (exp_q.size() < DEPTH) exp_q.push_back(d[7:0]); else m_txo = 1'b1;
      ADR_STS: begin
        if (d[4]) m_txo = 1'b0;
        if (d[5]) m_rxu = 1'b0;
      end
      ADR_DIV: m_div = (d[15:0] == 16'd0) ? 16'd1 : d[15:0];
`ifdef WB_UART_IRQ_EN
      ADR_IER: m_ier = d[2:0];
`endif
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [4:0] a, output logic [31:0] e);
    int lvl;
    lvl = exp_q.size();
    e = 32'd0;
    case ({a[4:2], 2'b00})
      ADR_RXD: if (ef) m_rxu = 1'b1; else begin rd_exp++; e = {24'd0, rx_data}; end
      ADR_STS: e = {16'd0, 8'(lvl), 2'b00, m_rxu, m_txo, (lvl == DEPTH), (lvl == 0), ef, busy};
      ADR_DIV: e = {16'd0, m_div};
      ADR_IER: e = {29'd0, m_ier};
      default: e = 32'd0;
    endcase
  endtask

  function automatic logic m_irq();
    return |(m_ier & {m_txo | m_rxu, exp_q.size() == 0, ~ef});
  endfunction

  task automatic wb_access(input logic we, input logic [4:0] a, input logic [31:0] d,
                           output logic [31:0] q);
    int n;
    n = 0;
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = a; wb.dat_w = d; wb.sel = 4'hF;
    do begin @(posedge clk); #1; n++; end while (!wb.ack && n < 8);
    if (!wb.ack) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack at addr %h after %0d cycles", a, n);
    end
    q = wb.dat_r;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_access(1'b1, a, d, q);
    model_write(a, d);
  endtask

  task automatic wb_rd(input logic [4:0] a, output logic [31:0] q, output logic [31:0] e);
    model_read(a, e);
    wb_access(1'b0, a, 32'd0, q);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && !pend && dbg == IDLE) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(exp_q.size() + 32'(busy)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, e;
    logic [4:0]  a;
    int s0, r0, r, n;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat_w = '0; wb.sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_ack", 32'(wb.ack), 32'd0);
    chk("rst_rd", 32'(rfifo_rd), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_baud", 32'(baud), 32'd868);
    wb_rd(ADR_DIV, q, e); chk("rst_div_rd", q, 32'd868);
    wb_rd(ADR_STS, q, e); chk("rst_sts_rd", q, 32'h0000_0006);

    // three bytes drained in order through the busy model
    busy_mode = 2;
    s0 = starts_seen;
    wb_wr(ADR_TXD, 32'h41);
    wb_wr(ADR_TXD, 32'h42);
    wb_wr(ADR_TXD, 32'h43);
    wait_drain(500, "t2_drain");
    chk("t2_starts", 32'(starts_seen - s0), 32'd3);
    chk("t2_last_data", 32'(utx_data), 32'h43);
    wb_rd(ADR_STS, q, e); chk("t2_sts", q, 32'h0000_0006);

    // overflow with the core held busy
    busy_mode = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 17; i++) wb_wr(ADR_TXD, 32'($urandom_range(0, 255)));
    wb_rd(ADR_STS, q, e); chk("t3_sts_full", q, 32'h0000_101B);
    wb_wr(ADR_STS, 32'h10);
    wb_rd(ADR_STS, q, e); chk("t3_sts_w1c", q, 32'h0000_100B);
    busy_mode = 2;
    wait_drain(1500, "t3_drain");

    // RX pops
    busy_mode = 0;
    repeat (2) @(posedge clk);
    r0 = rd_seen;
    wb_rd(ADR_RXD, q, e); chk("t4_rxd_empty", q, 32'd0);
    wb_rd(ADR_STS, q, e); chk("t4_sts_rxu", q, 32'h0000_0026);
    chk("t4_no_pop", 32'(rd_seen - r0), 32'd0);
    ef = 1'b0; rx_data = 8'h5A;
    wb_rd(ADR_RXD, q, e); chk("t4_rxd_5a", q, 32'h0000_005A);
    @(posedge clk); #1;
    chk("t4_one_pop", 32'(rd_seen - r0), 32'd1);
    ef = 1'b1;

    // divisor clamp and interrupt
    wb_wr(ADR_DIV, 32'd0);
    wb_rd(ADR_DIV, q, e); chk("t5_div_rd", q, 32'd1);
    chk("t5_baud", 32'(baud), 32'd1);
    wb_wr(ADR_IER, 32'h2);
    @(posedge clk); #1;
`ifdef WB_UART_IRQ_EN
    chk("t5_irq_empty", 32'(irq), 32'd1);
    wb_rd(ADR_IER, q, e); chk("t5_ier_rd", q, 32'd2);
`else
    chk("t5_irq_empty", 32'(irq), 32'd0);
    wb_rd(ADR_IER, q, e); chk("t5_ier_rd", q, 32'd0);
`endif
    busy_mode = 1;
    repeat (2) @(posedge clk);
    wb_wr(ADR_TXD, 32'h77);
    @(posedge clk); #1;
    chk("t5_irq_nonempty", 32'(irq), 32'd0);

    // randomized traffic with the core held busy so the FIFO level is deterministic
    for (int i = 0; i < 80; i++) begin
      ef = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 4) wb_wr(ADR_TXD, $urandom);
      else begin
        a = 5'($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 1) == 1) wb_wr(a, $urandom);
        else begin
          wb_rd(a, q, e);
          chk($sformatf("rnd_rd_%02h", a), q, e);
        end
      end
      @(posedge clk); #1;
`ifdef WB_UART_IRQ_EN
      chk("rnd_irq", 32'(irq), 32'(m_irq()));
`endif
      chk("rnd_pop_count", 32'(rd_seen), 32'(rd_exp));
    end
    busy_mode = 2;
    wait_drain(2000, "rnd_drain");
    wb_rd(ADR_STS, q, e); chk("rnd_sts_final", q, e);

    // async reset with bytes queued and the drain FSM waiting on the core
    ef = 1'b1;
    busy_mode = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) wb_wr(ADR_TXD, 32'(8'hA0 + i));
    busy_mode = 2;
    n = 0;
    while (dbg != WAIT_D && n < 40) begin @(posedge clk); #1; n++; end
    chk("t6_reach_wait_d", 32'(dbg), 32'(WAIT_D));
    rst_n = 1'b0;
    exp_q.delete();
    m_div = 16'd868; m_txo = 1'b0; m_rxu = 1'b0; m_ier = 3'd0;
    busy_mode = 0;
    #2;
    chk("t6_start_low", 32'(start), 32'd0);
    chk("t6_state_idle", 32'(dbg), 32'(IDLE));
    chk("t6_baud_rst", 32'(baud), 32'd868);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    wb_rd(ADR_STS, q, e); chk("t6_sts", q, 32'h0000_0006);
    wb_rd(ADR_DIV, q, e); chk("t6_div", q, 32'd868);
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
